// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and width helper.
// Used by both the BCD-to-binary and binary-to-BCD paths.
package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] DABBLE_ADJ     = 4'd3;
  localparam logic [3:0] RDABBLE_THRESH = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  function automatic int min_bin_w(input int digits);
    longint v;
    int     w;
    v = 1;
    w = 0;
    for (int i = 0; i < digits; i++) v = v * 10;
    while ((longint'(1) << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_rcorrect.sv
// Reverse double-dabble digit correction: subtract 3 from a
// post-shift BCD digit that is 8 or more.
module bcd_digit_rcorrect
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  assign q = (d >= RDABBLE_THRESH) ? d - DABBLE_ADJ : d;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one shift per clock.
// Optional digit range check: `BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out
`ifdef BCD2BIN_DIGIT_CHECK_EN
  ,
  output logic                          err
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);

  if (BIN_W < min_bin_w(DIGITS)) begin : g_w_chk
    $error("BIN_W too small for DIGITS");
  end

  bcd_state_e       state;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_sh;
  logic [SR_W-1:0]  sr_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             finish;
  logic             res_bad;

  logic [BCD_DIGIT_W-1:0] dig_cor [DIGITS];

  assign sr_sh = sr_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cor
    bcd_digit_rcorrect u_cor (
      .d (sr_sh[BIN_W+BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .q (dig_cor[g])
    );
  end

  always_comb begin
    sr_nx = sr_sh;
    for (int i = 0; i < DIGITS; i++)
      sr_nx[BIN_W+BCD_DIGIT_W*i +: BCD_DIGIT_W] = dig_cor[i];
  end

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign finish   = (state == SHIFT) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr_q  <= {bcd_in, {BIN_W{1'b0}}};
            cnt_q <= CNT_INIT;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q <= sr_nx;
          if (cnt_q == '0) begin
            bin_out   <= res_bad ? '0 : sr_nx[BIN_W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic bad_in;
  logic bad_q;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT)
        bad_in = 1'b1;
  end

  assign res_bad = bad_q;

  // err only becomes visible together with the result it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      bad_q <= bad_in;
      err   <= 1'b0;
    end else if (finish) begin
      err   <= bad_q;
    end
  end
`else
  assign res_bad = 1'b0;
`endif

endmodule
